wb_burst_master: RTL

//  Command-driven Wishbone B3 master that sits directly upstream of wb_ram (or any B3 burst slave).
//  - Accepts {we, adr, len} commands; issues one linear incrementing burst per command.
//  - Write data enters on a valid/ready stream; read data leaves on a valid/last stream.
//  - Reports completion and bus error per command.

---
 rtl/wb_burst_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B3 master: one linear incrementing burst per {we, adr, len} command,
// write data from a valid/ready stream, read data onto a valid/last stream, done/err per command.
`timescale 1ns/1ps
module wb_burst_master #(
    parameter int aw = 32,
    parameter int dw = 32,
    parameter int lw = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [aw-1:0]   cmd_adr_i,
    input  logic [lw-1:0]   cmd_len_i,
    input  logic            wdat_valid_i,
    output logic            wdat_ready_o,
    input  logic [dw-1:0]   wdat_i,
    output logic            rdat_valid_o,
    output logic [dw-1:0]   rdat_o,
    output logic            rdat_last_o,
    output logic            done_o,
    output logic            err_o,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [dw-1:0]   wb_dat_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_END} state_t;

    localparam logic [aw-1:0] ADR_STEP = aw'(dw / 8);

    state_t          state_q, state_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic [lw-1:0]   len_q, len_d;
    logic [lw-1:0]   beat_q, beat_d;
    logic [lw:0]     fetch_q, fetch_d;
    logic            we_q, we_d;
    logic            dv_q, dv_d;
    logic [dw-1:0]   dat_q, dat_d;
    logic            cyc_q, cyc_d;
    logic [dw-1:0]   rdat_q, rdat_d;
    logic            rdat_valid_q, rdat_valid_d;
    logic            rdat_last_q, rdat_last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            last_beat;
    logic            stb;
    logic            bus_err;
    logic            beat;
    logic            fetch_left;
    logic            wdat_ready;
    logic            take;

    assign last_beat  = (beat_q == len_q);
    assign stb        = cyc_q & (~we_q | dv_q);
    assign bus_err    = stb & wb_err_i;
    assign beat       = stb & wb_ack_i & ~wb_err_i;
    assign fetch_left = (fetch_q != ({1'b0, len_q} + (lw + 1)'(1)));
    // Refill is allowed in the same cycle the held word is acked, giving zero-bubble writes.
    assign wdat_ready = (state_q == S_BUS) & we_q & fetch_left & (~dv_q | beat);
    assign take       = wdat_valid_i & wdat_ready;

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        fetch_d      = fetch_q;
        we_d         = we_q;
        dv_d         = dv_q;
        dat_d        = dat_q;
        cyc_d        = cyc_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        rdat_last_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d   = cmd_adr_i;
                    len_d   = cmd_len_i;
                    we_d    = cmd_we_i;
                    beat_d  = '0;
                    fetch_d = '0;
                    dv_d    = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_err) begin
                    cyc_d   = 1'b0;
                    dv_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_END;
                end else if (beat) begin
                    adr_d  = adr_q + ADR_STEP;
                    beat_d = beat_q + lw'(1);
                    dv_d   = 1'b0;
                    if (!we_q) begin
                        rdat_d       = wb_dat_i;
                        rdat_valid_d = 1'b1;
                        rdat_last_d  = last_beat;
                    end
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_END;
                    end
                end
                if (take) begin
                    dat_d   = wdat_i;
                    dv_d    = 1'b1;
                    fetch_d = fetch_q + (lw + 1)'(1);
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            fetch_q      <= '0;
            we_q         <= 1'b0;
            dv_q         <= 1'b0;
            dat_q        <= '0;
            cyc_q        <= 1'b0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            rdat_last_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            fetch_q      <= fetch_d;
            we_q         <= we_d;
            dv_q         <= dv_d;
            dat_q        <= dat_d;
            cyc_q        <= cyc_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            rdat_last_q  <= rdat_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign wdat_ready_o = wdat_ready;
    assign rdat_valid_o = rdat_valid_q;
    assign rdat_o       = rdat_q;
    assign rdat_last_o  = rdat_last_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = '1;
    assign wb_we_o      = cyc_q & we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb;
    assign wb_cti_o     = cyc_q ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wb_bte_o     = 2'b00;

endmodule
